edge_pulse_gen: RTL and testbench

Multi-channel, parametrised edge-to-pulse generator. Each channel synchronises an asynchronous or debounced level input, detects rising, falling or both edges under per-channel mode control, and emits a registered pulse of configurable length. An optional sticky pending/interrupt stage lets the TramelBlaze service edge events through a register interface. It replaces single-channel rising-edge pulse logic between the debounce stage and the RS flop / interrupt logic.

---
 rtl/edge_pulse_gen.sv | 113 +++++++++++
 tb/tb_edge_pulse_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse generator: synchroniser, mode-qualified edge detect and stretched pulse per channel.
// Define EDGE_PULSE_STICKY_EN to build the sticky pending/overrun/irq stage; otherwise those outputs are tied to 0.
module edge_pulse_gen #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CHANNELS-1:0]     din,
   input  logic [2*CHANNELS-1:0]   mode,
   input  logic [CHANNELS-1:0]     clr,
   output logic [CHANNELS-1:0]     pulse,
   output logic [CHANNELS-1:0]     pending,
   output logic [CHANNELS-1:0]     overrun,
   output logic                    irq
);

   localparam int              CNT_W    = $clog2(PULSE_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CHANNELS-1:0] ev;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] s;
      logic                   p;
      logic                   s_last;
      logic                   ev_c;
      logic [CNT_W-1:0]       cnt;
      logic [CNT_W-1:0]       cnt_nxt;
      logic                   pulse_q;

      assign s_last = s[SYNC_STAGES-1];

      // Mode is used live; there is no latched copy, so a change applies on the next cycle.
      always_comb begin
         ev_c = 1'b0;
         unique case (mode[2*i +: 2])
            2'b01:   ev_c = s_last & ~p;
            2'b10:   ev_c = ~s_last & p;
            2'b11:   ev_c = s_last ^ p;
            default: ev_c = 1'b0;
         endcase
      end

      // A new edge reloads the counter, so close edges merge into one longer pulse.
      always_comb begin
         cnt_nxt = cnt;
         if (ev_c) begin
            cnt_nxt = CNT_LOAD;
         end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_ONE;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s       <= '0;
            p       <= 1'b0;
            cnt     <= '0;
            pulse_q <= 1'b0;
         end else begin
            s       <= {s[SYNC_STAGES-2:0], din[i]};
            p       <= s_last;
            cnt     <= cnt_nxt;
            pulse_q <= (cnt_nxt != '0);
         end
      end

      assign ev[i]    = ev_c;
      assign pulse[i] = pulse_q;
   end

`ifdef EDGE_PULSE_STICKY_EN
   for (genvar i = 0; i < CHANNELS; i++) begin : g_sticky
      logic pend_q;
      logic ovr_q;

      // Set beats clear: an event arriving with its clear strobe is never dropped.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
         end else begin
            if (ev[i]) begin
               pend_q <= 1'b1;
            end else if (clr[i]) begin
               pend_q <= 1'b0;
            end
            if (ev[i] && pend_q && !clr[i]) begin
               ovr_q <= 1'b1;
            end else if (clr[i]) begin
               ovr_q <= 1'b0;
            end
         end
      end

      assign pending[i] = pend_q;
      assign overrun[i] = ovr_q;
   end

   assign irq = |pending;
`else
   logic unused_sticky;

   assign unused_sticky = ^{clr, ev};
   assign pending       = '0;
   assign overrun       = '0;
   assign irq           = 1'b0;
`endif

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: three instances (PULSE_LEN 1, 5, 8) share stimulus and are checked every
// cycle against a cycle-level model through an expected-value queue, plus directed width/count checks.
module tb_edge_pulse_gen;

   localparam int CH = 4;
   localparam int SS = 2;
   localparam int ND = 3;
   localparam int W  = 3*CH + 1;

`ifdef EDGE_PULSE_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic [CH-1:0]   din   = '0;
   logic [CH-1:0]   clr   = '0;
   logic [2*CH-1:0] mode  = {CH{2'b01}};

   logic [CH-1:0] pulse_a, pending_a, overrun_a;
   logic [CH-1:0] pulse_b, pending_b, overrun_b;
   logic [CH-1:0] pulse_c, pending_c, overrun_c;
   logic          irq_a, irq_b, irq_c;

   edge_pulse_gen #(.CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_LEN(1)) u_dut_l1 (
      .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
      .pulse(pulse_a), .pending(pending_a), .overrun(overrun_a), .irq(irq_a));

   edge_pulse_gen #(.CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_LEN(5)) u_dut_l5 (
      .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
      .pulse(pulse_b), .pending(pending_b), .overrun(overrun_b), .irq(irq_b));

   edge_pulse_gen #(.CHANNELS(CH), .SYNC_STAGES(SS), .PULSE_LEN(8)) u_dut_l8 (
      .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
      .pulse(pulse_c), .pending(pending_c), .overrun(overrun_c), .irq(irq_c));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit hist [CH][SS+1];   // din samples: [0..SS-1] sync chain, [SS] history
   int mcnt [ND][CH];
   bit mpend[CH];
   bit movr [CH];

   int hi_cnt    [ND][CH];
   int rise_cnt  [ND][CH];
   int first_rise[ND][CH];
   bit prev_pls  [ND][CH];

   function automatic int plen_of(input int d);
      case (d)
         0:       return 1;
         1:       return 5;
         default: return 8;
      endcase
   endfunction

   function automatic logic [W-1:0] dut_obs(input int d);
      case (d)
         0:       return {pulse_a, pending_a, overrun_a, irq_a};
         1:       return {pulse_b, pending_b, overrun_b, irq_b};
         default: return {pulse_c, pending_c, overrun_c, irq_c};
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         for (int j = 0; j <= SS; j++) hist[c][j] = 1'b0;
         mpend[c] = 1'b0;
         movr[c]  = 1'b0;
         for (int d = 0; d < ND; d++) mcnt[d][c] = 0;
      end
   endfunction

   function automatic void model_tick();
      bit newer, older, ev;
      if (reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CH; c++) begin
         newer = hist[c][SS-1];
         older = hist[c][SS];
         case (mode[2*c +: 2])
            2'b01:   ev = newer && !older;
            2'b10:   ev = !newer && older;
            2'b11:   ev = newer != older;
            default: ev = 1'b0;
         endcase
         for (int d = 0; d < ND; d++)
            mcnt[d][c] = ev ? plen_of(d) : (mcnt[d][c] > 0 ? mcnt[d][c] - 1 : 0);
         if (STICKY) begin
            if (ev && mpend[c] && !clr[c]) movr[c] = 1'b1;
            else if (clr[c])               movr[c] = 1'b0;
            if (ev)          mpend[c] = 1'b1;
            else if (clr[c]) mpend[c] = 1'b0;
         end
         for (int j = SS; j > 0; j--) hist[c][j] = hist[c][j-1];
         hist[c][0] = din[c];
      end
   endfunction

   function automatic logic [W-1:0] model_exp(input int d);
      logic [CH-1:0] pv, ev_p, ev_o;
      for (int c = 0; c < CH; c++) begin
         pv[c]   = (mcnt[d][c] > 0);
         ev_p[c] = mpend[c];
         ev_o[c] = movr[c];
      end
      return {pv, ev_p, ev_o, |ev_p};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_counters();
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < CH; c++) begin
            hi_cnt[d][c]     = 0;
            rise_cnt[d][c]   = 0;
            first_rise[d][c] = -1;
         end
   endtask

   task automatic step();
      logic [W-1:0] got, e;
      @(posedge clk);
      cyc++;
      model_tick();
      for (int d = 0; d < ND; d++) exp_q.push_back(model_exp(d));
      #1;
      for (int d = 0; d < ND; d++) begin
         got = dut_obs(d);
         e   = exp_q.pop_front();
         check_eq($sformatf("pulse_L%0d", plen_of(d)),   32'(got[W-1 -: CH]), 32'(e[W-1 -: CH]));
         check_eq($sformatf("pending_L%0d", plen_of(d)), 32'(got[2*CH -: CH]), 32'(e[2*CH -: CH]));
         check_eq($sformatf("overrun_L%0d", plen_of(d)), 32'(got[CH -: CH]), 32'(e[CH -: CH]));
         check_eq($sformatf("irq_L%0d", plen_of(d)),     32'(got[0]), 32'(e[0]));
         for (int c = 0; c < CH; c++) begin
            if (got[2*CH + 1 + c]) begin
               hi_cnt[d][c]++;
               if (!prev_pls[d][c]) begin
                  rise_cnt[d][c]++;
                  if (first_rise[d][c] < 0) first_rise[d][c] = cyc;
               end
            end
            prev_pls[d][c] = got[2*CH + 1 + c];
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_clr(input logic [CH-1:0] m);
      clr = m;
      step();
      clr = '0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      int waited;
      model_reset();
      clear_counters();
      for (int d = 0; d < ND; d++) for (int c = 0; c < CH; c++) prev_pls[d][c] = 1'b0;

      // Reset defaults
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) check_eq($sformatf("reset_outputs_L%0d", plen_of(d)), 32'(dut_obs(d)), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run(3);

      // Rising edge on channel 0
      clear_counters();
      t0 = cyc;
      din[0] = 1'b1;
      run(12);
      check_eq("rise_latency_L1", 32'(first_rise[0][0] - t0), 32'(SS + 1));
      check_eq("rise_width_L1",   32'(hi_cnt[0][0]), 32'd1);
      check_eq("rise_width_L5",   32'(hi_cnt[1][0]), 32'd5);
      check_eq("rise_width_L8",   32'(hi_cnt[2][0]), 32'd8);
      check_eq("rise_pending0",   32'(pending_a[0]), 32'(STICKY));
      check_eq("rise_irq",        32'(irq_a), 32'(STICKY));
      pulse_clr('1);
      run(2);

      // Falling-only then both-edge mode on channel 1
      mode[3:2] = 2'b10;
      clear_counters();
      din[1] = 1'b1; run(10);
      din[1] = 1'b0; run(10);
      check_eq("fall_mode_pulses", 32'(rise_cnt[0][1]), 32'd1);
      mode[3:2] = 2'b11;
      clear_counters();
      din[1] = 1'b1; run(10);
      din[1] = 1'b0; run(10);
      check_eq("both_mode_pulses", 32'(rise_cnt[0][1]), 32'd2);

      // Retrigger on channel 2
      mode[5:4] = 2'b11;
      clear_counters();
      din[2] = 1'b1; run(3);
      din[2] = 1'b0; run(15);
      check_eq("retrig_width_L5",  32'(hi_cnt[1][2]), 32'd8);
      check_eq("retrig_pulses_L5", 32'(rise_cnt[1][2]), 32'd1);
      clear_counters();
      din[2] = 1'b1; run(10);
      din[2] = 1'b0; run(15);
      check_eq("sep_width_L5",  32'(hi_cnt[1][2]), 32'd10);
      check_eq("sep_pulses_L5", 32'(rise_cnt[1][2]), 32'd2);
      check_eq("sep_pulses_L8", 32'(rise_cnt[2][2]), 32'd2);

      // Sticky flags on channel 3
      pulse_clr('1);
      mode[7:6] = 2'b11;
      din[3] = 1'b1; run(6);
      din[3] = 1'b0; run(6);
      check_eq("sticky_pending", 32'(pending_a[3]), 32'(STICKY));
      check_eq("sticky_overrun", 32'(overrun_a[3]), 32'(STICKY));
      din[3] = 1'b1;
      run(2);
      pulse_clr(4'b1000);          // clear lands on the cycle the new edge qualifies
      check_eq("clr_vs_edge_pending", 32'(pending_a[3]), 32'(STICKY));
      check_eq("clr_vs_edge_overrun", 32'(overrun_a[3]), 32'd0);
      run(4);
      pulse_clr('1);
      step();
      check_eq("clr_alone_pending", 32'(pending_a), 32'd0);
      check_eq("clr_alone_overrun", 32'(overrun_a), 32'd0);
      check_eq("clr_alone_irq",     32'(irq_a), 32'd0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) == 0) din[$urandom_range(0, CH-1)] ^= 1'b1;
         if ($urandom_range(0, 19) == 0) mode = 2*CH'($urandom());
         clr = ($urandom_range(0, 3) == 0) ? CH'($urandom()) : '0;
         step();
      end
      clr = '0;

      // Reset mid-pulse with din held high
      mode = {CH{2'b01}};
      din  = '0;
      run(6);
      pulse_clr('1);
      run(2);
      din[0] = 1'b1;
      waited = 0;
      while (!pulse_c[0] && waited < 20) begin
         step();
         waited++;
      end
      check_eq("wait_pulse_L8", 32'(pulse_c[0]), 32'd1);
      run(2);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("midreset_pulse",   32'(pulse_c), 32'd0);
      check_eq("midreset_pending", 32'(pending_c), 32'd0);
      check_eq("midreset_irq",     32'(irq_c), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int d = 0; d < ND; d++) for (int c = 0; c < CH; c++) prev_pls[d][c] = 1'b0;
      clear_counters();
      run(20);
      check_eq("post_reset_events_L8", 32'(rise_cnt[2][0]), 32'd1);
      check_eq("post_reset_width_L8",  32'(hi_cnt[2][0]), 32'd8);
      check_eq("post_reset_pending",   32'(pending_c[0]), 32'(STICKY));

      // Final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
